// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shifter arbiter/sequencer.
//   state_t              : sequencer states (IDLE -> ISSUE -> CAPTURE).
//   SRC_ALIGN / SRC_NORM : source tag values, also used as round-robin
//                          "last winner" encoding.
//   DIR_RIGHT / DIR_LEFT : shifter direction encoding.
package shift_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic SRC_ALIGN = 1'b0;
    localparam logic SRC_NORM  = 1'b1;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en             : grants are only produced (and history only updated) when high
//   req_a, req_n   : requests from the align and norm units
//   gnt_a, gnt_n   : combinational one-hot grants
// The last winner resets to norm so that align wins the first tie.
module rr_arbiter2
    import shift_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_n,
    output logic gnt_a,
    output logic gnt_n
);

    logic last_winner;

    // On a tie, the requester that did not win last time gets the grant.
    always_comb begin
        gnt_a = 1'b0;
        gnt_n = 1'b0;
        if (en) begin
            if (req_a && req_n) begin
                if (last_winner == SRC_NORM) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_n = 1'b1;
                end
            end else begin
                gnt_a = req_a;
                gnt_n = req_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= SRC_NORM;
        end else if (gnt_a) begin
            last_winner <= SRC_ALIGN;
        end else if (gnt_n) begin
            last_winner <= SRC_NORM;
        end
    end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Sequencer/arbiter sharing one registered barrel shifter between the
// exponent-alignment unit (right shift) and the normalization unit
// (left shift). One operation completes every three cycles:
// grant (IDLE) -> load (ISSUE) -> capture (CAPTURE) -> result pulse.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   align_req_i/value_i/data_i/gnt_o  : alignment requester handshake
//   norm_req_i/value_i/data_i/gnt_o   : normalization requester handshake
//   shift_load_o/value_o/data_o       : shifter controls and operand
//   left_right_o, bit_shift_o         : direction (1 = left), fill bit
//   shifter_result_i                  : shifter registered output
//   result_o/result_valid_o/result_src_o : captured result, pulse, source tag
//   busy_o                            : high while an op is in flight
//   shift_sat_o                       : shift value was clamped
// Build option: define SHIFT_ARB_SATURATE_EN to clamp shift values >= SWR
// to SWR and report it on shift_sat_o; otherwise shift_sat_o is 0.
module shift_arbiter_ctrl
    import shift_arb_pkg::*;
#(
    parameter int SWR = 26,
    parameter int EWR = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           align_req_i,
    input  logic [EWR-1:0] align_value_i,
    input  logic [SWR-1:0] align_data_i,
    output logic           align_gnt_o,
    input  logic           norm_req_i,
    input  logic [EWR-1:0] norm_value_i,
    input  logic [SWR-1:0] norm_data_i,
    output logic           norm_gnt_o,
    output logic           shift_load_o,
    output logic [EWR-1:0] shift_value_o,
    output logic [SWR-1:0] shift_data_o,
    output logic           left_right_o,
    output logic           bit_shift_o,
    input  logic [SWR-1:0] shifter_result_i,
    output logic [SWR-1:0] result_o,
    output logic           result_valid_o,
    output logic           result_src_o,
    output logic           busy_o,
    output logic           shift_sat_o
);

    state_t         state;
    state_t         state_next;
    logic           arb_en;
    logic           gnt_a;
    logic           gnt_n;
    logic           grant;
    logic [EWR-1:0] sel_value;
    logic [EWR-1:0] reg_value;
    logic [SWR-1:0] sel_data;

    // Grants are suppressed during reset so nothing is accepted in that cycle.
    assign arb_en = (state == IDLE) && !rst;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req_a (align_req_i),
        .req_n (norm_req_i),
        .gnt_a (gnt_a),
        .gnt_n (gnt_n)
    );

    assign grant       = gnt_a || gnt_n;
    assign align_gnt_o = gnt_a;
    assign norm_gnt_o  = gnt_n;
    assign sel_value   = gnt_n ? norm_value_i : align_value_i;
    assign sel_data    = gnt_n ? norm_data_i  : align_data_i;

    assign shift_load_o = (state == ISSUE);
    assign busy_o       = (state == ISSUE) || (state == CAPTURE);
    assign bit_shift_o  = 1'b0;

`ifdef SHIFT_ARB_SATURATE_EN
    localparam logic [EWR-1:0] SAT_VALUE = EWR'(SWR);
    logic sel_sat;

    assign sel_sat   = (sel_value >= SAT_VALUE);
    assign reg_value = sel_sat ? SAT_VALUE : sel_value;

    // Saturation flag follows the registered shift value and holds until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_sat_o <= 1'b0;
        end else if (grant) begin
            shift_sat_o <= sel_sat;
        end
    end
`else
    assign reg_value   = sel_value;
    assign shift_sat_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shifter controls are latched only at grant, so they stay stable through
    // ISSUE and hold afterwards; result_src changes at grant, which is after
    // the previous result pulse has been presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_value_o  <= '0;
            shift_data_o   <= '0;
            left_right_o   <= DIR_RIGHT;
            result_src_o   <= SRC_ALIGN;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= (state == CAPTURE);
            if (state == CAPTURE) begin
                result_o <= shifter_result_i;
            end
            if (grant) begin
                shift_value_o <= reg_value;
                shift_data_o  <= sel_data;
                left_right_o  <= gnt_n ? DIR_LEFT : DIR_RIGHT;
                result_src_o  <= gnt_n ? SRC_NORM : SRC_ALIGN;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Testbench for shift_arbiter_ctrl: directed operations with literal
// expectations, a round-robin/reset scenario, then randomized requesters.
// A timing-based reference model checks every DUT output each cycle.
module tb_shift_arbiter_ctrl;

    localparam int SWR = 26;
    localparam int EWR = 8;

    logic           clk;
    logic           rst;
    logic           align_req;
    logic [EWR-1:0] align_value;
    logic [SWR-1:0] align_data;
    logic           align_gnt;
    logic           norm_req;
    logic [EWR-1:0] norm_value;
    logic [SWR-1:0] norm_data;
    logic           norm_gnt;
    logic           shift_load;
    logic [EWR-1:0] shift_value;
    logic [SWR-1:0] shift_data;
    logic           left_right;
    logic           bit_shift;
    logic [SWR-1:0] shifter_q;
    logic [SWR-1:0] result;
    logic           result_valid;
    logic           result_src;
    logic           busy;
    logic           shift_sat;

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    shift_arbiter_ctrl #(.SWR(SWR), .EWR(EWR)) dut (
        .clk              (clk),
        .rst              (rst),
        .align_req_i      (align_req),
        .align_value_i    (align_value),
        .align_data_i     (align_data),
        .align_gnt_o      (align_gnt),
        .norm_req_i       (norm_req),
        .norm_value_i     (norm_value),
        .norm_data_i      (norm_data),
        .norm_gnt_o       (norm_gnt),
        .shift_load_o     (shift_load),
        .shift_value_o    (shift_value),
        .shift_data_o     (shift_data),
        .left_right_o     (left_right),
        .bit_shift_o      (bit_shift),
        .shifter_result_i (shifter_q),
        .result_o         (result),
        .result_valid_o   (result_valid),
        .result_src_o     (result_src),
        .busy_o           (busy),
        .shift_sat_o      (shift_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered barrel shifter shared by both requesters.
    initial shifter_q = '0;
    always @(posedge clk) begin
        if (shift_load) begin
            shifter_q <= left_right ? (shift_data << shift_value) : (shift_data >> shift_value);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model: an op granted at cycle g loads at g+1, is captured at
    // g+2 and reports at g+3; a new grant is possible whenever no op is at g+1/g+2.
    int             cyc = 0;
    int             g_cycle = -100;
    bit             last_norm = 1'b1;
    logic [SWR-1:0] m_data = '0;
    logic [EWR-1:0] m_value = '0;
    logic           m_lr = 1'b0;
    logic           m_src = 1'b0;
    logic           m_sat = 1'b0;
    logic [SWR-1:0] m_result = '0;
    logic [SWR-1:0] op_result = '0;
    bit             mdl_gnt_a = 1'b0;
    bit             mdl_gnt_n = 1'b0;

    always @(negedge clk) begin
        int             d;
        bit             ga;
        bit             gn;
        logic [EWR-1:0] v;
        logic [SWR-1:0] dt;
        logic           s;
        if (model_on) begin
            d  = cyc - g_cycle;
            ga = 1'b0;
            gn = 1'b0;
            if (!rst && !(d == 1 || d == 2)) begin
                if (align_req && norm_req) begin
                    if (last_norm) ga = 1'b1; else gn = 1'b1;
                end else if (align_req) begin
                    ga = 1'b1;
                end else if (norm_req) begin
                    gn = 1'b1;
                end
            end
            checkOutput("align_gnt",    32'(align_gnt),    32'(ga));
            checkOutput("norm_gnt",     32'(norm_gnt),     32'(gn));
            checkOutput("busy",         32'(busy),         32'(d == 1 || d == 2));
            checkOutput("shift_load",   32'(shift_load),   32'(d == 1));
            checkOutput("result_valid", 32'(result_valid), 32'(d == 3));
            checkOutput("result",       32'(result),       32'(m_result));
            checkOutput("result_src",   32'(result_src),   32'(m_src));
            checkOutput("shift_data",   32'(shift_data),   32'(m_data));
            checkOutput("shift_value",  32'(shift_value),  32'(m_value));
            checkOutput("left_right",   32'(left_right),   32'(m_lr));
            checkOutput("bit_shift",    32'(bit_shift),    32'(0));
            checkOutput("shift_sat",    32'(shift_sat),    32'(m_sat));
            mdl_gnt_a = ga;
            mdl_gnt_n = gn;
            if (rst) begin
                g_cycle   = cyc - 100;
                last_norm = 1'b1;
                m_data    = '0;
                m_value   = '0;
                m_lr      = 1'b0;
                m_src     = 1'b0;
                m_sat     = 1'b0;
                m_result  = '0;
            end else begin
                if (d == 2) m_result = op_result;
                if (ga || gn) begin
                    v  = gn ? norm_value : align_value;
                    dt = gn ? norm_data : align_data;
`ifdef SHIFT_ARB_SATURATE_EN
                    s = (v >= 8'd26);
                    if (s) v = 8'd26;
`else
                    s = 1'b0;
`endif
                    m_data    = dt;
                    m_value   = v;
                    m_lr      = gn;
                    m_src     = gn;
                    m_sat     = s;
                    op_result = gn ? (dt << v) : (dt >> v);
                    last_norm = gn;
                    g_cycle   = cyc;
                end
            end
            cyc++;
        end
    end

    // Runs one isolated op from an idle DUT; entered and left at posedge+1.
    task automatic applyStimulus(input bit is_norm, input logic [SWR-1:0] data, input logic [EWR-1:0] value,
                                 input logic [SWR-1:0] exp_res, input logic [EWR-1:0] exp_val, input logic exp_sat);
        if (is_norm) begin
            norm_req = 1'b1; norm_data = data; norm_value = value;
        end else begin
            align_req = 1'b1; align_data = data; align_value = value;
        end
        @(negedge clk);
        checkOutput("dir_gnt", 32'(is_norm ? norm_gnt : align_gnt), 32'(1));
        @(posedge clk); #1;
        align_req = 1'b0;
        norm_req  = 1'b0;
        @(negedge clk);
        checkOutput("dir_load",  32'(shift_load),  32'(1));
        checkOutput("dir_lr",    32'(left_right),  32'(is_norm));
        checkOutput("dir_value", 32'(shift_value), 32'(exp_val));
        checkOutput("dir_sat",   32'(shift_sat),   32'(exp_sat));
        @(negedge clk);
        @(negedge clk);
        checkOutput("dir_valid",  32'(result_valid), 32'(1));
        checkOutput("dir_result", 32'(result),       32'(exp_res));
        checkOutput("dir_src",    32'(result_src),   32'(is_norm));
        @(posedge clk); #1;
    endtask

    task automatic newAlign();
        align_data  = SWR'($urandom);
        align_value = ($urandom_range(0, 7) == 0) ? EWR'($urandom_range(0, 255)) : EWR'($urandom_range(0, 25));
    endtask

    task automatic newNorm();
        norm_data  = SWR'($urandom);
        norm_value = ($urandom_range(0, 7) == 0) ? EWR'($urandom_range(0, 255)) : EWR'($urandom_range(0, 25));
    endtask

    initial begin
        rst = 1'b1;
        align_req = 1'b0; align_value = '0; align_data = '0;
        norm_req  = 1'b0; norm_value  = '0; norm_data  = '0;
        @(posedge clk);
        model_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(1'b0, 26'h2000000, 8'd3,  26'h0400000, 8'd3,  1'b0);
        applyStimulus(1'b1, 26'h0000100, 8'd17, 26'h2000000, 8'd17, 1'b0);
`ifdef SHIFT_ARB_SATURATE_EN
        applyStimulus(1'b0, 26'h3FFFFFF, 8'd40, 26'h0000000, 8'd26, 1'b1);
`else
        applyStimulus(1'b0, 26'h3FFFFFF, 8'd40, 26'h0000000, 8'd40, 1'b0);
`endif

        // Both requesting continuously from reset: A, N, A with a grant in
        // the result cycle, then reset during the third op's CAPTURE.
        rst = 1'b1;
        align_req = 1'b1; align_data = 26'h0000F00; align_value = 8'd4;
        norm_req  = 1'b1; norm_data  = 26'h0000003; norm_value  = 8'd2;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("rr_first_a", 32'(align_gnt), 32'(1));
            if (k == 3) begin
                checkOutput("rr_second_n",  32'(norm_gnt),     32'(1));
                checkOutput("rr_valid_gnt", 32'(result_valid), 32'(1));
                checkOutput("rr_result0",   32'(result),       32'(26'h00000F0));
            end
            if (k == 6) checkOutput("rr_third_a", 32'(align_gnt), 32'(1));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rr_capture_busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_valid",  32'(result_valid), 32'(0));
        checkOutput("rst_busy",   32'(busy),         32'(0));
        checkOutput("rst_result", 32'(result),       32'(0));
        checkOutput("rst_value",  32'(shift_value),  32'(0));
        checkOutput("rst_gnt",    32'({align_gnt, norm_gnt}), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_tie_a", 32'(align_gnt), 32'(1));
        @(posedge clk); #1;
        align_req = 1'b0;
        norm_req  = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end

        // Randomized requesters obeying the hold-until-granted rule.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (align_req) begin
                if (mdl_gnt_a) begin
                    if ($urandom_range(0, 1) == 1) newAlign(); else align_req = 1'b0;
                end
            end else if ($urandom_range(0, 9) < 4) begin
                align_req = 1'b1;
                newAlign();
            end
            if (norm_req) begin
                if (mdl_gnt_n) begin
                    if ($urandom_range(0, 1) == 1) newNorm(); else norm_req = 1'b0;
                end
            end else if ($urandom_range(0, 9) < 4) begin
                norm_req = 1'b1;
                newNorm();
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        align_req = 1'b0;
        norm_req  = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter_ctrl.md
Name: shift_arbiter_ctrl

Overview:
- Sequencer/arbiter that shares one registered barrel shifter (1-cycle output register, load-enabled) between two requesters in the add/subtract datapath.
  - Requester A: exponent-alignment unit (right shift).
  - Requester N: normalization unit (left shift by leading-zero count).
- Drives the shifter's load, shift value, direction and fill-bit controls.
- Captures the shifter output and returns it, with source tag, to the requesters.

Parameters:
- SWR, 26, shifter data width (implicit bit + significand + guard + round).
- EWR, 8, shift-value width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- align_req_i  in  1  alignment request; held until granted.
- align_value_i  in  EWR  right-shift amount.
- align_data_i  in  SWR  operand to align.
- align_gnt_o  out  1  one-cycle grant to align requester.
- norm_req_i  in  1  normalization request; held until granted.
- norm_value_i  in  EWR  left-shift amount.
- norm_data_i  in  SWR  operand to normalize.
- norm_gnt_o  out  1  one-cycle grant to norm requester.
- shift_load_o  out  1  load enable to shifter output register.
- shift_value_o  out  EWR  shift amount to shifter.
- shift_data_o  out  SWR  operand to shifter.
- left_right_o  out  1  direction; 1 = left, 0 = right.
- bit_shift_o  out  1  fill bit shifted in.
- shifter_result_i  in  SWR  shifter registered output.
- result_o  out  SWR  captured result.
- result_valid_o  out  1  one-cycle pulse; result_o valid.
- result_src_o  out  1  0 = align, 1 = norm.
- busy_o  out  1  high in ISSUE/CAPTURE.
- shift_sat_o  out  1  saturation flag (see Optional Feature).

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE; any in-flight op is dropped and no result_valid_o is produced for it.
  - All outputs are 0.
  - last_winner = norm, so align wins the first tie.
- States IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE:
  - If any request is asserted, pick the winner: a single requester wins outright; if both request, round-robin gives the grant to the requester not granted last.
  - Assert the winner's gnt combinationally in this cycle.
  - Register the winner's data, value and direction into the shift_* outputs; set result_src; update last_winner; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - shift_load_o = 1 for exactly one cycle; controls are held stable.
  - Align: left_right_o = 0, bit_shift_o = 0.
  - Norm: left_right_o = 1, bit_shift_o = 0.
- CAPTURE:
  - shifter_result_i is valid; register it into result_o and go to IDLE.
  - result_valid_o is registered and pulses in the following (IDLE) cycle, together with result_o and result_src_o.
- Latency and throughput:
  - Grant at cycle T, load at T+1, result_valid_o at T+3.
  - IDLE may grant a new request in the same cycle result_valid_o is high, so one op completes every 3 cycles.
- Requester rules:
  - Request data is sampled only in the grant cycle.
  - A requester deasserts its req in the cycle after gnt, or keeps it asserted to request again.
- Hold rules:
  - result_o holds its last value until the next CAPTURE.
  - shift_* outputs hold after ISSUE; shift_load_o is 0 outside ISSUE.
- Shift value: passed unchanged; the value width is EWR.

Optional Feature:
- Macro: SHIFT_ARB_SATURATE_EN.
- Defined:
  - A selected shift value >= SWR is clamped to SWR in the registered shift_value_o.
  - shift_sat_o is set alongside the shift_* registration and holds until the next grant.
- Undefined: the value is passed unchanged and shift_sat_o is tied to 0.

Decomposition:
- Package shift_arb_pkg:
  - State enum {IDLE, ISSUE, CAPTURE}.
  - SRC_ALIGN = 0, SRC_NORM = 1.
  - DIR_RIGHT = 0, DIR_LEFT = 1.
- Sub-module rr_arbiter2: two-request round-robin with last_winner register and an enable that updates it only when a grant is issued.

Test Plan (SWR = 26, EWR = 8):
- Align alone: align_data 26'h2000000, value 3 -> grant at T, load at T+1, result 26'h0400000 with src 0 and left_right 0, result_valid_o at T+3.
- Norm alone: norm_data 26'h0000100, value 17 -> result 26'h2000000, src 1, left_right 1.
- Both requesting continuously from reset -> grants alternate A, N, A, N with results every 3 cycles; no grant while busy_o = 1.
- Reset asserted in CAPTURE -> next cycle all outputs 0, no result_valid_o; the next tie is granted to align.
- New request held during the result_valid_o cycle -> granted in that same cycle.
- SHIFT_ARB_SATURATE_EN, align value 40 -> shift_value_o = 26, shift_sat_o = 1, result 0.
  - Without the macro: shift_value_o = 40, shift_sat_o = 0.
